// File: rtl/ext_uart.sv
// Bus-mapped 8N1 UART with 8-deep TX/RX FIFOs, programmable bit divisor and 2-flop RX sync.
// Optional interrupt output and enables are built when EXT_UART_IRQ_EN is defined.
module ext_uart #(
    parameter logic [15:0] CLK_DIV_RST = 16'd434,
    parameter int unsigned FIFO_AW     = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_addr,
    input  logic        i_stb,
    input  logic [3:0]  i_we,
    input  logic [31:0] i_dat_w,
    output logic        o_ack,
    output logic [31:0] o_dat_r,
    input  logic        i_rx,
    output logic        o_tx
`ifdef EXT_UART_IRQ_EN
    ,
    output logic        o_irq
`endif
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [1:0]  rst_pipe;
    logic        ready;
    logic        accept, is_wr;
    logic [1:0]  reg_sel;
    logic [15:0] divisor;
    logic [31:0] status, rd_data;

    logic [7:0]         tx_mem [DEPTH];
    logic [FIFO_AW:0]   tx_wp, tx_rp;
    logic               tx_fifo_empty, tx_full, tx_push, tx_pop, tx_empty;
    tx_state_t          tx_state;
    logic [15:0]        tx_cnt;
    logic [7:0]         tx_sh;
    logic [2:0]         tx_bit;

    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_AW:0]   rx_wp, rx_rp;
    logic               rx_empty, rx_full, rx_push, rx_pop;
    rx_state_t          rx_state;
    logic [15:0]        rx_cnt;
    logic [7:0]         rx_sh;
    logic [2:0]         rx_bit;
    logic               rx_meta, rx_s, rx_prev;
    logic               stop_sample, overrun_set, ferr_set;
    logic               rx_overrun, frame_err;
    logic               status_rd;
    logic               unused_bits;

`ifdef EXT_UART_IRQ_EN
    logic rx_ie, tx_ie;
`endif

    assign unused_bits = ^{i_addr[15:4], i_addr[1:0], i_dat_w[31:16]};

    // Deassertion of reset is pipelined so the bus stays closed for two edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign ready = rst_pipe[1];

    assign accept    = i_stb & ~o_ack & ready;
    assign is_wr     = |i_we;
    assign reg_sel   = i_addr[3:2];
    assign tx_push   = accept & is_wr & (reg_sel == 2'd0) & ~tx_full;
    assign rx_pop    = accept & ~is_wr & (reg_sel == 2'd0) & ~rx_empty;
    assign status_rd = accept & ~is_wr & (reg_sel == 2'd1);

    assign tx_fifo_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                      (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                      (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
    assign tx_empty = tx_fifo_empty & (tx_state == TX_IDLE);
    assign tx_pop   = ~tx_fifo_empty &
                      ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == 16'd0));

    assign stop_sample = (rx_state == RX_STOP) && (rx_cnt == 16'd0);
    assign rx_push     = stop_sample & rx_s & ~rx_full;
    assign overrun_set = stop_sample & rx_s & rx_full;
    assign ferr_set    = stop_sample & ~rx_s;

    always_comb begin
        status    = '0;
        status[0] = tx_full;
        status[1] = tx_empty;
        status[2] = ~rx_empty;
        status[3] = rx_overrun;
        status[4] = frame_err;
`ifdef EXT_UART_IRQ_EN
        status[5] = rx_ie;
        status[6] = tx_ie;
`endif
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0:    rd_data = rx_empty ? '0 : {24'd0, rx_mem[rx_rp[FIFO_AW-1:0]]};
            2'd1:    rd_data = status;
            2'd2:    rd_data = {16'd0, divisor};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ack      <= 1'b0;
            o_dat_r    <= '0;
            divisor    <= CLK_DIV_RST;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            o_ack   <= accept;
            o_dat_r <= (accept && !is_wr) ? rd_data : '0;
            if (accept && is_wr && reg_sel == 2'd2)
                divisor <= (i_dat_w[15:0] < 16'd4) ? 16'd4 : i_dat_w[15:0];
            // A new event on the same edge as a status read wins over the clear.
            if (overrun_set)    rx_overrun <= 1'b1;
            else if (status_rd) rx_overrun <= 1'b0;
            if (ferr_set)       frame_err  <= 1'b1;
            else if (status_rd) frame_err  <= 1'b0;
        end
    end

`ifdef EXT_UART_IRQ_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_ie <= 1'b0;
            tx_ie <= 1'b0;
            o_irq <= 1'b0;
        end else begin
            if (accept && is_wr && reg_sel == 2'd1) begin
                rx_ie <= i_dat_w[5];
                tx_ie <= i_dat_w[6];
            end
            o_irq <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | rx_overrun | frame_err;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= i_dat_w[7:0];
        if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end

    // Each bit reloads its counter from the live divisor, so a rewrite lands on the next bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state <= TX_IDLE;
            o_tx     <= 1'b1;
            tx_cnt   <= '0;
            tx_sh    <= '0;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!tx_fifo_empty) begin
                        tx_state <= TX_START;
                        o_tx     <= 1'b0;
                        tx_sh    <= tx_mem[tx_rp[FIFO_AW-1:0]];
                        tx_cnt   <= divisor - 16'd1;
                    end
                end
                TX_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= TX_DATA;
                        o_tx     <= tx_sh[0];
                        tx_bit   <= '0;
                        tx_cnt   <= divisor - 16'd1;
                    end else tx_cnt <= tx_cnt - 16'd1;
                end
                TX_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= divisor - 16'd1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            o_tx     <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                            o_tx   <= tx_sh[1];
                        end
                    end else tx_cnt <= tx_cnt - 16'd1;
                end
                TX_STOP: begin
                    if (tx_cnt == 16'd0) begin
                        if (!tx_fifo_empty) begin
                            tx_state <= TX_START;
                            o_tx     <= 1'b0;
                            tx_sh    <= tx_mem[tx_rp[FIFO_AW-1:0]];
                            tx_cnt   <= divisor - 16'd1;
                        end else tx_state <= TX_IDLE;
                    end else tx_cnt <= tx_cnt - 16'd1;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_sh    <= '0;
            rx_bit   <= '0;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= {1'b0, divisor[15:1]} - 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (rx_s) rx_state <= RX_IDLE;
                        else begin
                            rx_state <= RX_DATA;
                            rx_bit   <= '0;
                            rx_cnt   <= divisor - 16'd1;
                        end
                    end else rx_cnt <= rx_cnt - 16'd1;
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_cnt <= divisor - 16'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else rx_cnt <= rx_cnt - 16'd1;
                end
                RX_STOP: begin
                    if (rx_cnt == 16'd0) rx_state <= RX_IDLE;
                    else                 rx_cnt   <= rx_cnt - 16'd1;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_uart.sv
// Directed self-checking bench for ext_uart: bus registers, TX framing, FIFO limits, RX paths, reset.
module tb_ext_uart;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic        stb = 1'b0;
    logic [3:0]  we = '0;
    logic [31:0] dat_w = '0;
    logic        ack;
    logic [31:0] dat_r;
    logic        rx = 1'b1;
    logic        tx;
`ifdef EXT_UART_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ext_uart #(.CLK_DIV_RST(16'd434), .FIFO_AW(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_addr  (addr),
        .i_stb   (stb),
        .i_we    (we),
        .i_dat_w (dat_w),
        .o_ack   (ack),
        .o_dat_r (dat_r),
        .i_rx    (rx),
        .o_tx    (tx)
`ifdef EXT_UART_IRQ_EN
        ,
        .o_irq   (irq)
`endif
    );

    task automatic xfer(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d,
                        output logic [31:0] r, output int lat);
        @(negedge clk);
        addr = a; we = w; dat_w = d; stb = 1'b1; lat = 0;
        @(posedge clk); #1;
        while (!ack && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL bus_ack addr=%h got=%b want=1", a, ack);
        end
        r = dat_r;
        stb = 1'b0; we = '0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        logic [31:0] r; int l;
        xfer(a, 4'hF, d, r, l);
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] r);
        int l;
        xfer(a, 4'h0, 32'd0, r, l);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int d);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); rx = f[k];
            repeat (d - 1) @(negedge clk);
        end
        @(negedge clk); rx = 1'b1;
    endtask

    task automatic decode_frame(output logic [7:0] b, output logic ok);
        int n;
        n = 0; ok = 1'b1; b = '0;
        while (tx && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        if (tx) begin
            ok = 1'b0;
            return;
        end
        repeat (8) @(posedge clk); #1;
        if (tx !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat (16) @(posedge clk); #1;
            b[k] = tx;
        end
        repeat (16) @(posedge clk); #1;
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] r; int lat;
        repeat (3) @(posedge clk); #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b want=1", tx); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b want=0", ack); end
        checks++; if (dat_r !== 32'd0) begin errors++; $display("FAIL rst_dat got=%h want=0", dat_r); end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        xfer(16'h0004, 4'h0, 32'd0, r, lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL ack_latency got=%0d want=0", lat); end
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL rst_status got=%h want=00000002", r); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx got=%b want=1", tx); end
        rd(16'h0008, r);
        checks++; if (r !== 32'd434) begin errors++; $display("FAIL rst_divisor got=%0d want=434", r); end
        wr(16'h000C, 32'hFFFF_FFFF);
        rd(16'h000C, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL reg_c got=%h want=0", r); end
        wr(16'h0008, 32'd2);
        rd(16'h0008, r);
        checks++; if (r !== 32'd4) begin errors++; $display("FAIL div_min got=%0d want=4", r); end
    endtask

    task automatic test_tx_frame;
        logic [9:0] frame; logic [31:0] r; int n; logic ok;
        frame = {1'b1, 8'h55, 1'b0};
        wr(16'h0008, 32'd8);
        wr(16'h0000, 32'h55);
        n = 0;
        while (tx && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL tx_start_delay got=%0d want=1", n); end
        for (int k = 0; k < 10; k++) begin
            ok = 1'b1;
            for (int j = 0; j < 8; j++) begin
                if (tx !== frame[k]) ok = 1'b0;
                @(posedge clk); #1;
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL tx_bit%0d got=%b want=%b for 8 clocks", k, tx, frame[k]); end
        end
        rd(16'h0004, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL tx_done_status got=%h want=00000002", r); end
    endtask

    task automatic test_tx_fifo_full;
        logic [7:0] exp_b [9]; logic [7:0] b; logic ok; logic [31:0] r; int n;
        exp_b[0] = 8'hA0;
        for (int i = 1; i < 9; i++) exp_b[i] = 8'hB0 + 8'(i - 1);
        wr(16'h0008, 32'd16);
        fork
            begin
                wr(16'h0000, 32'hA0);
                repeat (3) @(posedge clk);
                for (int i = 0; i < 9; i++) begin
                    wr(16'h0000, 32'hB0 + i);
                    if (i == 6 || i == 7 || i == 8) begin
                        rd(16'h0004, r);
                        checks++;
                        if (r[0] !== (i >= 7)) begin
                            errors++;
                            $display("FAIL tx_full_after_%0d got=%b want=%b", i + 1, r[0], (i >= 7));
                        end
                    end
                end
            end
            begin
                for (int f = 0; f < 9; f++) begin
                    decode_frame(b, ok);
                    checks++;
                    if (!ok || b !== exp_b[f]) begin
                        errors++;
                        $display("FAIL tx_frame%0d got=%h ok=%b want=%h", f, b, ok, exp_b[f]);
                    end
                end
            end
        join
        n = 0;
        while (tx && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_extra_frame got=%b want=1", tx); end
    endtask

    task automatic test_rx_byte;
        logic [31:0] r;
        send_rx(8'hA3, 1'b1, 16);
        repeat (4) @(negedge clk);
        rd(16'h0004, r);
        checks++; if (r[2] !== 1'b1) begin errors++; $display("FAIL rx_valid got=%b want=1", r[2]); end
        rd(16'h0000, r);
        checks++; if (r !== 32'hA3) begin errors++; $display("FAIL rx_data got=%h want=000000a3", r); end
        rd(16'h0004, r);
        checks++; if (r[2] !== 1'b0) begin errors++; $display("FAIL rx_valid_after got=%b want=0", r[2]); end
    endtask

    task automatic test_rx_overrun;
        logic [31:0] r;
        for (int i = 0; i < 9; i++) send_rx(8'h31 + 8'(i), 1'b1, 16);
        repeat (4) @(negedge clk);
        rd(16'h0004, r);
        checks++;
        if (r[4:2] !== 3'b011) begin errors++; $display("FAIL overrun_status got=%b want=011", r[4:2]); end
        for (int i = 0; i < 8; i++) begin
            rd(16'h0000, r);
            checks++;
            if (r !== 32'h31 + i) begin errors++; $display("FAIL overrun_data%0d got=%h want=%h", i, r, 32'h31 + i); end
        end
        rd(16'h0004, r);
        checks++;
        if (r[3:2] !== 2'b00) begin errors++; $display("FAIL overrun_cleared got=%b want=00", r[3:2]); end
    endtask

    task automatic test_rx_errors;
        logic [31:0] r;
        @(negedge clk); rx = 1'b0;
        repeat (3) @(negedge clk); rx = 1'b1;
        repeat (40) @(negedge clk);
        rd(16'h0004, r);
        checks++; if (r[4:2] !== 3'b000) begin errors++; $display("FAIL glitch_status got=%b want=000", r[4:2]); end
        send_rx(8'h5A, 1'b0, 16);
        repeat (20) @(negedge clk);
        rd(16'h0004, r);
        checks++; if (r[4:2] !== 3'b100) begin errors++; $display("FAIL frame_err_status got=%b want=100", r[4:2]); end
        rd(16'h0000, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL empty_read got=%h want=0", r); end
        rd(16'h0004, r);
        checks++; if (r[4] !== 1'b0) begin errors++; $display("FAIL frame_err_clear got=%b want=0", r[4]); end
    endtask

    task automatic test_reset_mid_tx;
        logic [31:0] r; int n;
        wr(16'h0000, 32'h00);
        n = 0;
        while (tx && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (30) @(posedge clk); #1;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_frame_tx got=%b want=0", tx); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_rst_tx got=%b want=1", tx); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL async_rst_ack got=%b want=0", ack); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rd(16'h0004, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL post_rst_status got=%h want=00000002", r); end
        rd(16'h0008, r);
        checks++; if (r !== 32'd434) begin errors++; $display("FAIL post_rst_div got=%0d want=434", r); end
        repeat (50) @(posedge clk); #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL post_rst_tx got=%b want=1", tx); end
    endtask

    initial begin
        test_reset;
        test_tx_frame;
        test_tx_fifo_full;
        test_rx_byte;
        test_rx_overrun;
        test_rx_errors;
        test_reset_mid_tx;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
